fb_scan_reader: RTL and testbench

Read-side initiator for the frame-buffer sram. On a start pulse it walks one whole frame in raster order, issuing single-port read requests (en=1, we=0). It absorbs the sram's one-cycle read latency in a small prefetch FIFO and presents pixels on a valid/ready stream with frame and line markers. It sits between the frame-buffer sram and the display/pixel pipeline.

---
 rtl/fb_scan_reader.sv | 160 ++++++++++++++++
 tb/tb_fb_scan_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// Frame-buffer read initiator: walks one frame in raster order through a single-port sram
// and streams the pixels out with sof/eol/eof markers behind a small prefetch FIFO.
module fb_scan_reader #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 17,
   parameter int H_PIX      = 320,
   parameter int V_PIX      = 240,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [DATA_WIDTH-1:0] sram_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  pix_eof,
   output logic                  frame_done
);

   localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_PIX * V_PIX - 1);
   localparam logic [XW-1:0]         X_LAST    = XW'(H_PIX - 1);
   localparam logic [YW-1:0]         Y_LAST    = YW'(V_PIX - 1);
   localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   typedef struct packed {
      logic                  sof;
      logic                  eol;
      logic                  eof;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [XW-1:0]           x;
   logic [YW-1:0]           y;
   logic                    inflight;
   logic                    infl_sof, infl_eol, infl_eof;
   entry_t                  fifo_mem [FIFO_DEPTH];
   entry_t                  head;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           count;
   logic [CW-1:0]           occupancy;
   logic                    issue, push, pop, frame_end;
   logic                    frame_done_q;

   // The in-flight read already owns a FIFO slot, so it counts toward occupancy.
   assign occupancy = count + CW'(inflight);
   assign push      = inflight;
   assign pop       = pix_valid & pix_ready;
   assign frame_end = (state == DRAIN) && pop && (count == CW'(1)) && !inflight;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            if (occupancy < DEPTH_C) begin
               issue = 1'b1;
               if (addr == LAST_ADDR) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (frame_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (state == IDLE && start)) begin
         addr <= '0;
         x    <= '0;
         y    <= '0;
      end else if (issue && addr != LAST_ADDR) begin
         addr <= addr + ADDR_WIDTH'(1);
         if (x == X_LAST) begin
            x <= '0;
            y <= y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   // Markers ride one stage alongside the read so they land in the FIFO with their data.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= 1'b0;
         infl_sof <= 1'b0;
         infl_eol <= 1'b0;
         infl_eof <= 1'b0;
      end else begin
         inflight <= issue;
         infl_sof <= (x == '0) && (y == '0);
         infl_eol <= (x == X_LAST);
         infl_eof <= (x == X_LAST) && (y == Y_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{sof: infl_sof, eol: infl_eol, eof: infl_eof, data: sram_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) frame_done_q <= 1'b0;
      else       frame_done_q <= frame_end;
   end

   // Head fields are masked while empty so the stream reads all-zero out of reset.
   assign head       = fifo_mem[rd_ptr];
   assign pix_valid  = (count != '0);
   assign pix_data   = pix_valid ? head.data : '0;
   assign pix_sof    = pix_valid & head.sof;
   assign pix_eol    = pix_valid & head.eol;
   assign pix_eof    = pix_valid & head.eof;
   assign busy       = (state != IDLE);
   assign sram_en    = issue;
   assign sram_we    = 1'b0;
   assign sram_addr  = addr;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader on a 4x3 frame; the sram model returns addr+0x100.
module tb_fb_scan_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        pix_ready = 1'b0;
   logic [11:0] sram_data = '0;
   logic        busy, sram_en, sram_we, pix_valid, pix_sof, pix_eol, pix_eof, frame_done;
   logic [16:0] sram_addr;
   logic [11:0] pix_data;

   int checks = 0;
   int passed = 0;

   int          cyc = 0;
   logic [16:0] addr_q[$];
   int          issue_cyc[$];
   logic [14:0] pix_q[$];
   int          xfer_cyc[$];
   int          fd_cyc_q[$];
   int          issued, xfers, fd_cnt, max_out, first_valid_cyc;
   bit          fd_busy, last_eof, we_seen;

   fb_scan_reader #(
      .DATA_WIDTH(12), .ADDR_WIDTH(17), .H_PIX(4), .V_PIX(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_data(sram_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_en) sram_data <= 12'(sram_addr) + 12'h100;
   end

   function automatic logic [14:0] exp_pix(int i);
      logic [14:0] e;
      e[11:0] = 12'h100 + 12'(i);
      e[14]   = (i == 0);
      e[13]   = (i % 4 == 3);
      e[12]   = (i == 11);
      return e;
   endfunction

   // Index of the first wrong pixel of a 12-pixel frame starting at off, or -1.
   function automatic int first_bad(int off);
      if (pix_q.size() < off + 12) return pix_q.size();
      for (int i = 0; i < 12; i++)
         if (pix_q[off + i] !== exp_pix(i)) return off + i;
      return -1;
   endfunction

   task automatic clear_logs();
      addr_q.delete(); issue_cyc.delete(); pix_q.delete(); xfer_cyc.delete(); fd_cyc_q.delete();
      issued = 0; xfers = 0; fd_cnt = 0; max_out = 0; first_valid_cyc = -1;
      fd_busy = 1'b1; last_eof = 1'b0; we_seen = 1'b0;
   endtask

   // Advance one cycle, drive this cycle's inputs, then log what the DUT shows.
   task automatic tick(input bit rdy, input bit st);
      @(posedge clk);
      #1;
      pix_ready = rdy;
      start     = st;
      cyc++;
      if (sram_we) we_seen = 1'b1;
      if (sram_en) begin
         addr_q.push_back(sram_addr);
         issue_cyc.push_back(cyc);
         issued++;
      end
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      last_eof = 1'b0;
      if (pix_valid && pix_ready) begin
         pix_q.push_back({pix_sof, pix_eol, pix_eof, pix_data});
         xfer_cyc.push_back(cyc);
         xfers++;
         last_eof = pix_eof;
      end
      if (frame_done) begin
         fd_cnt++;
         fd_cyc_q.push_back(cyc);
         fd_busy = busy;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(0, 0);
      tick(0, 0);
      checks++;
      if ({pix_valid, busy, sram_en, sram_we, frame_done} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {pix_valid, busy, sram_en, sram_we, frame_done});
      else passed++;
      checks++;
      if ({pix_data, pix_sof, pix_eol, pix_eof} !== 15'h0)
         $display("[TB] FAIL reset_pix: got %h expected 0000", {pix_data, pix_sof, pix_eol, pix_eof});
      else passed++;
      reset = 1'b0;
      tick(1, 0);
   endtask

   task automatic test_basic();
      int bad_addr;
      clear_logs();
      tick(1, 1);
      tick(1, 0);
      checks++;
      if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", busy);
      else passed++;
      for (int c = 0; c < 60 && fd_cnt == 0; c++) tick(1, 0);
      checks++;
      if (fd_cnt !== 1) $display("[TB] FAIL basic_done: got %0d frame_done expected 1", fd_cnt);
      else passed++;
      bad_addr = (addr_q.size() == 12) ? -1 : 99;
      for (int i = 0; i < addr_q.size() && bad_addr < 0; i++)
         if (addr_q[i] !== 17'(i) || issue_cyc[i] != issue_cyc[0] + i) bad_addr = i;
      checks++;
      if (bad_addr >= 0) $display("[TB] FAIL basic_addr: %0d reads, first bad %0d expected 12 consecutive 0..11", addr_q.size(), bad_addr);
      else passed++;
      checks++;
      if (issue_cyc.size() == 0 || first_valid_cyc != issue_cyc[0] + 2)
         $display("[TB] FAIL basic_latency: first valid cycle %0d expected first issue+2", first_valid_cyc);
      else passed++;
      checks++;
      if (first_bad(0) != -1) $display("[TB] FAIL basic_pixels: first bad index %0d expected -1", first_bad(0));
      else passed++;
      checks++;
      if (xfer_cyc.size() != 12 || xfer_cyc[11] != xfer_cyc[0] + 11)
         $display("[TB] FAIL basic_gapless: %0d transfers not back to back, expected 12 in 12 cycles", xfer_cyc.size());
      else passed++;
      checks++;
      if (xfer_cyc.size() != 12 || fd_cyc_q.size() == 0 || fd_cyc_q[0] != xfer_cyc[11] + 1 || fd_busy !== 1'b0)
         $display("[TB] FAIL basic_done_timing: done busy=%b expected done one cycle after eof with busy 0", fd_busy);
      else passed++;
      checks++;
      if (we_seen) $display("[TB] FAIL basic_we: got sram_we 1 expected 0");
      else passed++;
   endtask

   task automatic test_backpressure();
      clear_logs();
      tick(0, 1);
      for (int c = 0; c < 10; c++) tick(0, 0);
      checks++;
      if (addr_q.size() != 4 || addr_q[3] !== 17'd3)
         $display("[TB] FAIL stall_reads: got %0d reads expected 4 (addr 0..3)", addr_q.size());
      else passed++;
      checks++;
      if ({sram_en, pix_valid, pix_data} !== {1'b0, 1'b1, 12'h100})
         $display("[TB] FAIL stall_hold: got en=%b valid=%b data=%h expected en=0 valid=1 data=100", sram_en, pix_valid, pix_data);
      else passed++;
      for (int c = 0; c < 60 && fd_cnt == 0; c++) tick(1, 0);
      checks++;
      if (first_bad(0) != -1 || fd_cnt != 1)
         $display("[TB] FAIL stall_resume: bad index %0d done %0d expected -1 and 1", first_bad(0), fd_cnt);
      else passed++;
   endtask

   task automatic test_toggle();
      clear_logs();
      tick(1, 1);
      for (int c = 0; c < 80 && fd_cnt == 0; c++) tick(c[0] == 1'b0, 0);
      checks++;
      if (first_bad(0) != -1 || pix_q.size() != 12)
         $display("[TB] FAIL toggle_pixels: bad index %0d count %0d expected -1 and 12", first_bad(0), pix_q.size());
      else passed++;
      checks++;
      if (max_out > 4) $display("[TB] FAIL toggle_occupancy: got %0d expected at most 4", max_out);
      else passed++;
      checks++;
      if (fd_cnt != 1) $display("[TB] FAIL toggle_done: got %0d expected 1", fd_cnt);
      else passed++;
   endtask

   task automatic test_start_mid();
      clear_logs();
      tick(1, 1);
      for (int c = 0; c < 60 && fd_cnt == 0; c++) tick(1, c == 4);
      for (int c = 0; c < 5; c++) tick(1, 0);
      checks++;
      if (addr_q.size() != 12 || first_bad(0) != -1)
         $display("[TB] FAIL midstart_frame: got %0d reads bad index %0d expected 12 and -1", addr_q.size(), first_bad(0));
      else passed++;
      checks++;
      if (fd_cnt != 1 || busy !== 1'b0)
         $display("[TB] FAIL midstart_done: got done %0d busy %b expected 1 and 0", fd_cnt, busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      clear_logs();
      tick(1, 1);
      for (int c = 0; c < 30 && xfers < 5; c++) tick(1, 0);
      tick(0, 0);
      reset = 1'b1;
      tick(1, 0);
      reset = 1'b0;
      checks++;
      if ({pix_valid, busy, sram_en, frame_done} !== 4'b0)
         $display("[TB] FAIL midreset_flush: got %b expected 0000", {pix_valid, busy, sram_en, frame_done});
      else passed++;
      for (int c = 0; c < 6; c++) tick(1, 0);
      checks++;
      if (fd_cnt != 0 || xfers != 5)
         $display("[TB] FAIL midreset_quiet: got done %0d xfers %0d expected 0 and 5", fd_cnt, xfers);
      else passed++;
      clear_logs();
      tick(1, 1);
      for (int c = 0; c < 60 && fd_cnt == 0; c++) tick(1, 0);
      checks++;
      if (addr_q.size() == 0 || addr_q[0] !== 17'd0 || first_bad(0) != -1 || fd_cnt != 1)
         $display("[TB] FAIL midreset_restart: bad index %0d done %0d expected -1 and 1", first_bad(0), fd_cnt);
      else passed++;
   endtask

   task automatic test_back_to_back();
      bit st_next;
      clear_logs();
      tick(1, 1);
      st_next = 1'b0;
      for (int c = 0; c < 100 && fd_cnt < 2; c++) begin
         tick(1, st_next);
         st_next = last_eof && (fd_cnt == 0);
      end
      checks++;
      if (fd_cnt != 2 || addr_q.size() != 24 || issue_cyc[12] != fd_cyc_q[0] + 1)
         $display("[TB] FAIL b2b_restart: got done %0d reads %0d expected 2 and 24, restart right after done", fd_cnt, addr_q.size());
      else passed++;
      checks++;
      if (first_bad(0) != -1 || first_bad(12) != -1 || pix_q.size() != 24)
         $display("[TB] FAIL b2b_pixels: bad %0d/%0d count %0d expected -1/-1 and 24", first_bad(0), first_bad(12), pix_q.size());
      else passed++;
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_basic();
      test_backpressure();
      test_toggle();
      test_start_mid();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
